// File: rtl/shared_bus_arbiter_pkg.sv
// Shared definitions for the L1/L2 shared bus: FSM encoding, default geometry
// and the select-width helper used by the arbiter and its interface.
package shared_bus_arbiter_pkg;

  localparam int BUS_NUM_CH = 4;
  localparam int BUS_DATA_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bus_state_e;

  // Index width for n channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_bus_arbiter_if.sv
// Request/grant/bus bundle between the L1 channels, the arbiter and the L2.
interface shared_bus_arbiter_if
  import shared_bus_arbiter_pkg::*;
#(
  parameter int NUM_CH = BUS_NUM_CH,
  parameter int DATA_W = BUS_DATA_W
);
  localparam int SEL_W = sel_width(NUM_CH);

  logic [NUM_CH-1:0]        req;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic                     l2_done;
  logic [NUM_CH-1:0]        gnt;
  logic                     l2_start;
  logic [DATA_W-1:0]        bus_out;
  logic [SEL_W-1:0]         bus_sel;
  logic [NUM_CH-1:0]        done;
  logic                     err;
  logic                     busy;

  modport master (
    input  req, req_data, l2_done,
    output gnt, l2_start, bus_out, bus_sel, done, err, busy
  );

  modport slave (
    output req, req_data, l2_done,
    input  gnt, l2_start, bus_out, bus_sel, done, err, busy
  );

endinterface

// File: rtl/shared_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_gnt,
// searching upward and wrapping.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  last_gnt_i,
  output logic [NUM_CH-1:0] winner_o,
  output logic [SEL_W-1:0]  idx_o,
  output logic              valid_o
);

  // One extra bit so last_gnt + NUM_CH never overflows before the wrap.
  logic [SEL_W:0] cand;

  always_comb begin
    winner_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = {1'b0, last_gnt_i} + (SEL_W+1)'(k);
      if (cand >= (SEL_W+1)'(NUM_CH)) begin
        cand = cand - (SEL_W+1)'(NUM_CH);
      end
      if (!valid_o && req_i[cand[SEL_W-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[SEL_W-1:0];
      end
    end
    if (valid_o) begin
      winner_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter giving NUM_CH L1 channels exclusive use of the L2 bus,
// one transaction at a time, with an L2 completion timeout.
module shared_bus_arbiter
  import shared_bus_arbiter_pkg::*;
#(
  parameter int NUM_CH  = BUS_NUM_CH,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shared_bus_arbiter_if.master bus
);

  localparam int SEL_W = sel_width(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT);

  bus_state_e        state_q, state_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
  logic [SEL_W-1:0]  last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_pend_q, err_pend_d;

  logic [NUM_CH-1:0] pick_onehot;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_valid;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_pick (
    .req_i      (bus.req),
    .last_gnt_i (last_gnt_q),
    .winner_o   (pick_onehot),
    .idx_o      (pick_idx),
    .valid_o    (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      bus_out_q  <= '0;
      bus_sel_q  <= '0;
      last_gnt_q <= SEL_W'(NUM_CH - 1);
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      bus_out_q  <= bus_out_d;
      bus_sel_q  <= bus_sel_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    bus_out_d  = bus_out_q;
    bus_sel_d  = bus_sel_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    unique case (state_q)
      ST_IDLE: begin
        // The bus word is captured once here; later req_data edits are ignored.
        if (pick_valid) begin
          state_d   = ST_START;
          gnt_d     = pick_onehot;
          bus_sel_d = pick_idx;
          bus_out_d = bus.req_data[pick_idx*DATA_W +: DATA_W];
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (bus.l2_done) begin
          state_d    = ST_RESP;
          err_pend_d = 1'b0;
          cnt_d      = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = ST_RESP;
          err_pend_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d    = ST_IDLE;
        last_gnt_d = bus_sel_q;
        gnt_d      = '0;
        bus_out_d  = '0;
        bus_sel_d  = '0;
        err_pend_d = 1'b0;
        cnt_d      = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.gnt      = gnt_q;
  assign bus.bus_out  = bus_out_q;
  assign bus.bus_sel  = bus_sel_q;
  assign bus.l2_start = (state_q == ST_START);
  assign bus.done     = (state_q == ST_RESP) ? gnt_q : '0;
  assign bus.err      = (state_q == ST_RESP) && err_pend_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter (NUM_CH=4, DATA_W=12, TIMEOUT=8).
module tb_shared_bus_arbiter;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  shared_bus_arbiter_if #(.NUM_CH(4), .DATA_W(12)) bus_if ();

  shared_bus_arbiter #(
    .NUM_CH  (4),
    .DATA_W  (12),
    .TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_eq("gnt_onehot0", 32'($onehot0(bus_if.gnt)), 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_gnt"},      32'(bus_if.gnt),      32'd0);
    check_eq({tag, "_busy"},     32'(bus_if.busy),     32'd0);
    check_eq({tag, "_done"},     32'(bus_if.done),     32'd0);
    check_eq({tag, "_err"},      32'(bus_if.err),      32'd0);
    check_eq({tag, "_l2_start"}, 32'(bus_if.l2_start), 32'd0);
    check_eq({tag, "_bus_out"},  32'(bus_if.bus_out),  32'd0);
    check_eq({tag, "_bus_sel"},  32'(bus_if.bus_sel),  32'd0);
  endtask

  // Starts in IDLE with req already driven; ends in IDLE after the RESP cycle.
  task automatic do_txn(input string name, input logic [3:0] exp_gnt, input logic [11:0] exp_data,
                        input int waits, input bit give_done, input bit exp_err, input bit drop_req);
    logic [47:0] saved;
    logic [1:0]  exp_sel;
    exp_sel = 2'd0;
    for (int i = 0; i < 4; i++) if (exp_gnt[i]) exp_sel = 2'(i);

    tick();
    check_eq({name, "_start_pulse"}, 32'(bus_if.l2_start), 32'd1);
    check_eq({name, "_start_gnt"},   32'(bus_if.gnt),      32'(exp_gnt));
    check_eq({name, "_start_sel"},   32'(bus_if.bus_sel),  32'(exp_sel));
    check_eq({name, "_start_data"},  32'(bus_if.bus_out),  32'(exp_data));
    check_eq({name, "_start_busy"},  32'(bus_if.busy),     32'd1);

    tick();
    saved = bus_if.req_data;
    bus_if.req_data = ~saved;
    if (drop_req) bus_if.req = 4'b0000;
    #1;
    check_eq({name, "_wait_pulse"}, 32'(bus_if.l2_start), 32'd0);
    check_eq({name, "_wait_data"},  32'(bus_if.bus_out),  32'(exp_data));
    check_eq({name, "_wait_gnt"},   32'(bus_if.gnt),      32'(exp_gnt));
    bus_if.req_data = saved;

    repeat (waits) tick();
    check_eq({name, "_early_done"}, 32'(bus_if.done), 32'd0);
    check_eq({name, "_wait_busy"},  32'(bus_if.busy), 32'd1);
    if (give_done) bus_if.l2_done = 1'b1;
    tick();
    bus_if.l2_done = 1'b0;
    check_eq({name, "_resp_done"}, 32'(bus_if.done), 32'(exp_gnt));
    check_eq({name, "_resp_err"},  32'(bus_if.err),  32'(exp_err));
    check_eq({name, "_resp_gnt"},  32'(bus_if.gnt),  32'(exp_gnt));
    $display("[TB] txn %s: gnt=%b bus_out=%h done=%b err=%0d", name,
             bus_if.gnt, exp_data, bus_if.done, bus_if.err);

    tick();
    check_eq({name, "_idle_done"}, 32'(bus_if.done),    32'd0);
    check_eq({name, "_idle_err"},  32'(bus_if.err),     32'd0);
    check_eq({name, "_idle_gnt"},  32'(bus_if.gnt),     32'd0);
    check_eq({name, "_idle_data"}, 32'(bus_if.bus_out), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    check_quiet("reset");
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    rst_n           = 1'b1;
    bus_if.req      = 4'b0000;
    bus_if.req_data = {12'h789, 12'h456, 12'h123, 12'hA5C};
    bus_if.l2_done  = 1'b0;
    #1;
    apply_reset();
    check_quiet("post_reset");

    // Single request, req dropped mid-transaction, bus word frozen.
    bus_if.req = 4'b0001;
    do_txn("single_ch0", 4'b0001, 12'hA5C, 2, 1'b1, 1'b0, 1'b1);
    tick();
    check_quiet("stay_idle");

    // All channels requesting after a fresh reset: 0,1,2,3,0.
    apply_reset();
    bus_if.req = 4'b1111;
    do_txn("rr_ch0", 4'b0001, 12'hA5C, 0, 1'b1, 1'b0, 1'b0);
    do_txn("rr_ch1", 4'b0010, 12'h123, 1, 1'b1, 1'b0, 1'b0);
    do_txn("rr_ch2", 4'b0100, 12'h456, 2, 1'b1, 1'b0, 1'b0);
    do_txn("rr_ch3", 4'b1000, 12'h789, 0, 1'b1, 1'b0, 1'b0);
    do_txn("rr_ch0b", 4'b0001, 12'hA5C, 0, 1'b1, 1'b0, 1'b0);
    bus_if.req = 4'b0000;

    // Wrap-around: last_gnt=3 then req=1001 picks ch0, then ch3.
    bus_if.req = 4'b1000;
    do_txn("wrap_pre_ch3", 4'b1000, 12'h789, 0, 1'b1, 1'b0, 1'b0);
    bus_if.req = 4'b1001;
    do_txn("wrap_ch0", 4'b0001, 12'hA5C, 1, 1'b1, 1'b0, 1'b0);
    do_txn("wrap_ch3", 4'b1000, 12'h789, 1, 1'b1, 1'b0, 1'b0);
    bus_if.req = 4'b0000;

    // Timeout: 8 WAIT cycles without l2_done, then a late l2_done is ignored.
    bus_if.req = 4'b0010;
    do_txn("timeout_ch1", 4'b0010, 12'h123, 7, 1'b0, 1'b1, 1'b0);
    bus_if.req = 4'b0000;
    bus_if.l2_done = 1'b1;
    tick();
    bus_if.l2_done = 1'b0;
    check_quiet("late_done");
    tick();
    check_quiet("late_done2");

    // l2_done on the final timeout cycle wins: err=0.
    bus_if.req = 4'b0100;
    do_txn("tie_ch2", 4'b0100, 12'h456, 7, 1'b1, 1'b0, 1'b0);
    bus_if.req = 4'b0000;

    // Reset during WAIT aborts silently and restores ch0 priority.
    bus_if.req = 4'b0001;
    tick();
    tick();
    tick();
    check_eq("abort_busy_before", 32'(bus_if.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("abort_async");
    tick();
    check_eq("abort_no_done", 32'(bus_if.done), 32'd0);
    rst_n = 1'b1;
    bus_if.req = 4'b1001;
    do_txn("after_abort_ch0", 4'b0001, 12'hA5C, 1, 1'b1, 1'b0, 1'b0);
    bus_if.req = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shared_bus_arbiter.md
SHARED_BUS_ARBITER -- requirements
Module: shared_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requesting channels (L1 caches), 2..16.
REQ-002 SHALL have parameter DATA_W, default 12: bus word width.
REQ-003 SHALL have parameter TIMEOUT, default 64: max cycles to wait for l2_done, at least 2.
REQ-004 SHALL define SEL_W = max(1, clog2(NUM_CH)).
REQ-005 clk  input  1  single clock, rising edge; one clock, reset asynchronous and active-low.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req  input  NUM_CH  per-channel request, level, held until that channel's done.
REQ-008 req_data  input  NUM_CH*DATA_W  per-channel bus word; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 l2_done  input  1  L2 completion pulse.
REQ-010 gnt  output  NUM_CH  one-hot grant, held for the whole transaction.
REQ-011 l2_start  output  1  one-cycle L2 start pulse.
REQ-012 bus_out  output  DATA_W  muxed word of the granted channel; zero when idle.
REQ-013 bus_sel  output  SEL_W  index of the granted channel.
REQ-014 done  output  NUM_CH  one-cycle completion pulse to the granted channel.
REQ-015 err  output  1  one-cycle timeout flag, coincident with done.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM SHALL have states IDLE, START, WAIT, RESP.
REQ-018 IDLE: if req is nonzero, SHALL select the winner and go to START; otherwise stay in IDLE.
REQ-019 Winner selection SHALL be round-robin: the first set req bit searching upward from (last_gnt+1) mod NUM_CH, wrapping.
REQ-020 START: gnt, bus_sel and bus_out SHALL be valid and l2_start = 1 for exactly this cycle; next state WAIT.
REQ-021 WAIT: gnt and bus_out SHALL be held; the timeout counter increments each cycle.
REQ-022 WAIT: on l2_done, SHALL go to RESP with err_pending = 0.
REQ-023 WAIT: when the counter reaches TIMEOUT-1 without l2_done, SHALL go to RESP with err_pending = 1.
REQ-024 WAIT: if l2_done and the timeout occur in the same cycle, l2_done SHALL win and err SHALL be 0.
REQ-025 RESP: done[gnt_idx] = 1, err = err_pending, last_gnt updated to gnt_idx, counter cleared; next state IDLE; gnt SHALL drop on leaving RESP.
REQ-026 Latency: req sampled in IDLE at edge N gives l2_start during cycle N+1; l2_done at edge M gives done during cycle M+1; minimum 4 cycles from req to return to IDLE.
REQ-027 l2_done outside WAIT SHALL be ignored.
REQ-028 A req drop mid-transaction SHALL be ignored; the transaction completes normally.
REQ-029 bus_out SHALL be registered from req_data at the IDLE-to-START edge; later req_data changes SHALL not affect it.
REQ-030 gnt SHALL be one-hot or zero at all times.
REQ-031 After RESP, the same channel SHALL not win again while any other channel is requesting.

Reset
REQ-032 While rst_n = 0, all state SHALL clear asynchronously: state = IDLE, gnt = 0, done = 0, err = 0, l2_start = 0, busy = 0, bus_out = 0, bus_sel = 0, counter = 0.
REQ-033 On reset, last_gnt SHALL be NUM_CH-1, so channel 0 has first priority.
REQ-034 Reset mid-transaction SHALL abort the transaction with no done pulse.

Structure
REQ-035 The shared bus package SHALL hold the FSM state encoding and the default DATA_W/NUM_CH constants, shared with the L1/L2 cache blocks.
REQ-036 Round-robin selection SHALL be a sub-module rr_pick (inputs req, last_gnt; output one-hot winner plus index), purely combinational.

Verification (NUM_CH=4, DATA_W=12, TIMEOUT=8)
REQ-037 Reset, then req=0001 with ch0 data 12'hA5C, l2_done 3 cycles after l2_start -> gnt=0001, bus_out=12'hA5C, done=0001 one cycle after l2_done, err=0.
REQ-038 req=1111 held for 4 transactions -> grant order ch0, ch1, ch2, ch3, then ch0 again.
REQ-039 req=1001 after last_gnt=3 -> ch0 granted (wrap-around); next grant is ch3.
REQ-040 No l2_done for 8 WAIT cycles -> done pulses for the granted channel with err=1, FSM returns to IDLE; l2_done arriving later is ignored.
REQ-041 Timeout and l2_done in the same cycle -> err=0; and rst_n low during WAIT -> all outputs 0 immediately, no done pulse, next grant goes to ch0.
